// File: rtl/vram_console_ctrl_pkg.sv
// Shared types and constants for the VRAM text-console controller.
package vram_console_pkg;

  // Controller states: normal operation, clearing one row, clearing the screen.
  typedef enum logic [1:0] {
    IDLE,
    CLR_ROW,
    CLR_ALL
  } console_state_t;

  // Round-robin pointer values; also the bit index of each requester.
  typedef enum logic {
    REQ_CONSOLE = 1'b0,
    REQ_DIRECT  = 1'b1
  } req_sel_t;

  // Console control codes.
  localparam logic [7:0] CR        = 8'h0D;
  localparam logic [7:0] LF        = 8'h0A;
  localparam logic [7:0] BS        = 8'h08;
  localparam logic [7:0] FF        = 8'h0C;
  localparam logic [7:0] PRINT_MIN = 8'h20;

  // Number of character cells on the screen.
  function automatic int screen_cells(input int cols, input int rows);
    return cols * rows;
  endfunction

endpackage

// File: rtl/vram_console_ctrl_if.sv
// Request-side bus of the console controller: UART byte stream and MCU direct writes.
interface vram_console_if #(
  parameter int ADDR_W = 12
);
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              wr_ack;

  // Requesters (UART path and MCU) drive the requests.
  modport master (
    output char_valid, char_data, wr_req, wr_addr, wr_data,
    input  char_ready, wr_ack
  );

  // The controller consumes the requests.
  modport slave (
    input  char_valid, char_data, wr_req, wr_addr, wr_data,
    output char_ready, wr_ack
  );
endinterface

// File: rtl/vram_console_ctrl_rr_arbiter.sv
// Two-requester round-robin arbiter; the pointer moves only on contention.
module vram_rr_arbiter
  import vram_console_pkg::*;
(
  input  logic       clk_72m,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  req_sel_t ptr;

  // Grant the pointed requester on contention, otherwise whoever asks.
  always_comb begin
    // NOTE: default first so every path assigns grant and no latch is inferred.
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) grant = (ptr == REQ_DIRECT) ? 2'b10 : 2'b01;
      else              grant = req;
    end
  end

  // Flip the pointer to the other requester after a contended grant.
  always_ff @(posedge clk_72m or negedge reset) begin
    if (!reset)                 ptr <= REQ_CONSOLE;
    else if (enable && &req)    ptr <= (ptr == REQ_DIRECT) ? REQ_CONSOLE : REQ_DIRECT;
  end

endmodule

// File: rtl/vram_console_ctrl.sv
// Text-console controller owning the write side of the LCD character VRAM.
module vram_console_ctrl
  import vram_console_pkg::*;
#(
  parameter int         COLS           = 30,
  parameter int         ROWS           = 25,
  parameter int         ADDR_W         = 12,
  parameter logic [7:0] ATTR           = 8'hF0,
  parameter logic [7:0] BLANK          = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk_72m,
  input  logic              reset,
  vram_console_if.slave     bus,
  output logic              vram_ce,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [15:0]       vram_data,
  output logic [4:0]        cursor_row,
  output logic [4:0]        cursor_col,
  output logic              busy
);

  localparam int                SCREEN_CELLS = screen_cells(COLS, ROWS);
  localparam logic [ADDR_W-1:0] LAST_CELL    = ADDR_W'(SCREEN_CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL_A   = ADDR_W'(COLS - 1);
  localparam logic [4:0]        LAST_COL     = 5'(COLS - 1);
  localparam logic [4:0]        LAST_ROW     = 5'(ROWS - 1);
  localparam logic [15:0]       BLANK_WORD   = {ATTR, BLANK};

  console_state_t    state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] cur_addr;
  logic [1:0]        grant;
  logic              idle;

  assign idle     = (state == IDLE);
  assign busy     = !idle;
  assign row_base = ADDR_W'(cursor_row) * ADDR_W'(COLS);
  assign cur_addr = row_base + ADDR_W'(cursor_col);

  vram_rr_arbiter u_arb (
    .clk_72m (clk_72m),
    .reset   (reset),
    .req     ({bus.wr_req, bus.char_valid}),
    .enable  (idle),
    .grant   (grant)
  );

  // With a byte pending, readiness is exactly the console grant; without one,
  // a waiting direct write holds the console off.
  assign bus.char_ready = bus.char_valid ? grant[REQ_CONSOLE] : (idle && !bus.wr_req);

  // Console state machine, cursor and registered VRAM write port.
  always_ff @(posedge clk_72m or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR_ON_RESET ? CLR_ALL : IDLE;
      clr_cnt    <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      vram_ce    <= 1'b0;
      vram_addr  <= '0;
      vram_data  <= '0;
      bus.wr_ack <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values;
      // the later assignments in a branch override these strobe defaults.
      vram_ce    <= 1'b0;
      bus.wr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant[REQ_DIRECT]) begin
            bus.wr_ack <= 1'b1;
            if (bus.wr_addr <= LAST_CELL) begin
              vram_ce   <= 1'b1;
              vram_addr <= bus.wr_addr;
              vram_data <= bus.wr_data;
            end
          end else if (grant[REQ_CONSOLE]) begin
            if (bus.char_data >= PRINT_MIN) begin
              vram_ce   <= 1'b1;
              vram_addr <= cur_addr;
              vram_data <= {ATTR, bus.char_data};
              if (cursor_col == LAST_COL) begin
                cursor_col <= '0;
                cursor_row <= (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
                clr_cnt    <= '0;
                state      <= CLR_ROW;
              end else begin
                cursor_col <= cursor_col + 5'd1;
              end
            end else begin
              case (bus.char_data)
                CR: cursor_col <= '0;
                LF: begin
                  cursor_row <= (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
                  clr_cnt    <= '0;
                  state      <= CLR_ROW;
                end
                BS: begin
                  if (cursor_col != 5'd0) begin
                    cursor_col <= cursor_col - 5'd1;
                    vram_ce    <= 1'b1;
                    vram_addr  <= cur_addr - ADDR_W'(1);
                    vram_data  <= BLANK_WORD;
                  end
                end
                FF: begin
                  clr_cnt <= '0;
                  state   <= CLR_ALL;
                end
                default: ;
              endcase
            end
          end
        end

        CLR_ROW: begin
          vram_ce   <= 1'b1;
          vram_addr <= row_base + clr_cnt;
          vram_data <= BLANK_WORD;
          if (clr_cnt == LAST_COL_A) begin
            clr_cnt <= '0;
            state   <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end

        CLR_ALL: begin
          vram_ce   <= 1'b1;
          vram_addr <= clr_cnt;
          vram_data <= BLANK_WORD;
          if (clr_cnt == LAST_CELL) begin
            clr_cnt    <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            state      <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_console_ctrl.sv
// Scoreboard bench for vram_console_ctrl: stimulus pushes expected VRAM/ack
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_vram_console_ctrl;

  typedef struct packed {
    logic        ce;
    logic        ack;
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk_72m = 1'b0;
  logic        reset   = 1'b0;
  logic        vram_ce;
  logic [11:0] vram_addr;
  logic [15:0] vram_data;
  logic [4:0]  cursor_row;
  logic [4:0]  cursor_col;
  logic        busy;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  vram_console_if #(.ADDR_W(12)) bus ();

  vram_console_ctrl dut (
    .clk_72m    (clk_72m),
    .reset      (reset),
    .bus        (bus),
    .vram_ce    (vram_ce),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #7 clk_72m = ~clk_72m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe or ack must match the head of the expected queue.
  always @(negedge clk_72m) begin
    if (vram_ce || bus.wr_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {vram_ce, bus.wr_ack, vram_addr, vram_data}, 32'h0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (e.ce) check("vram_write", {vram_ce, bus.wr_ack, vram_addr, vram_data}, e);
        else      check("ack_only", {30'd0, vram_ce, bus.wr_ack}, {30'd0, e.ce, e.ack});
      end
    end
  end

  task automatic push_wr(input logic [11:0] addr, input logic [15:0] data);
    exp_q.push_back('{ce: 1'b1, ack: 1'b0, addr: addr, data: data});
  endtask

  task automatic push_clear(input int first, input int count);
    for (int i = 0; i < count; i++) push_wr(12'(first + i), 16'hF020);
  endtask

  // Present one byte at a negedge and hold it until accepted (bounded).
  task automatic send_char(input logic [7:0] b);
    int n = 0;
    bus.char_valid = 1'b1;
    bus.char_data  = b;
    while (!bus.char_ready && n < 2000) begin
      @(negedge clk_72m);
      n++;
    end
    if (n >= 2000) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk_72m);
    bus.char_valid = 1'b0;
  endtask

  // Printable byte at the current cursor; expected write pushed here.
  task automatic send_print(input logic [7:0] b, input int row, input int col);
    push_wr(12'(row * 30 + col), {8'hF0, b});
    send_char(b);
  endtask

  // Line feed from a given row; expected row clear pushed here.
  task automatic send_lf(input int row);
    push_clear(((row == 24) ? 0 : row + 1) * 30, 30);
    send_char(8'h0A);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 5000) begin
      @(negedge clk_72m);
      n++;
    end
    @(negedge clk_72m);
    check(name, exp_q.size(), 0);
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk_72m);
      n++;
    end
    check(name, n, 750);
  endtask

  initial begin
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.wr_req     = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;

    // Reset state.
    repeat (3) @(negedge clk_72m);
    check("rst_outputs", {vram_ce, bus.wr_ack, vram_addr, vram_data}, 32'h0);
    check("rst_cursor", {cursor_row, cursor_col}, 32'h0);
    check("rst_busy", busy, 1);
    check("rst_char_ready", bus.char_ready, 0);

    // Power-up clear.
    push_clear(0, 750);
    reset = 1'b1;
    count_busy("powerup_busy_cycles");
    check("powerup_char_ready", bus.char_ready, 1);
    check("powerup_cursor", {cursor_row, cursor_col}, 32'h0);
    drain("powerup_drain");

    // Single printable byte.
    send_print(8'h41, 0, 0);
    drain("a_drain");
    check("a_cursor", {cursor_row, cursor_col}, {5'd0, 5'd1});

    // Move to (3,0) via CR and three line feeds.
    send_char(8'h0D);
    for (int r = 0; r < 3; r++) send_lf(r);
    drain("lf3_drain");
    check("row3_cursor", {cursor_row, cursor_col}, {5'd3, 5'd0});

    // Full row of printable bytes, then automatic row clear.
    for (int i = 0; i < 30; i++) send_print(8'(8'h41 + i), 3, i);
    push_clear(120, 30);
    begin
      int low = 0;
      while (!bus.char_ready && low < 200) begin
        @(negedge clk_72m);
        low++;
      end
      check("wrap_ready_low_cycles", low, 30);
    end
    drain("wrap_drain");
    check("wrap_cursor", {cursor_row, cursor_col}, {5'd4, 5'd0});

    // Walk down to (24,5).
    for (int r = 4; r < 24; r++) send_lf(r);
    for (int c = 0; c < 5; c++) send_print(8'h30 + 8'(c), 24, c);
    drain("row24_drain");
    check("row24_cursor", {cursor_row, cursor_col}, {5'd24, 5'd5});

    // Row wrap on LF, then backspace.
    send_lf(24);
    drain("lf_wrap_drain");
    check("lf_wrap_cursor", {cursor_row, cursor_col}, {5'd0, 5'd5});
    push_wr(12'd4, 16'hF020);
    send_char(8'h08);
    drain("bs_drain");
    check("bs_cursor", {cursor_row, cursor_col}, {5'd0, 5'd4});

    // Contention: four grants alternate console / direct.
    push_wr(12'd4, 16'hF05A);
    exp_q.push_back('{ce: 1'b1, ack: 1'b1, addr: 12'h100, data: 16'h1234});
    push_wr(12'd5, 16'hF05A);
    exp_q.push_back('{ce: 1'b1, ack: 1'b1, addr: 12'h100, data: 16'h1234});
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h5A;
    bus.wr_req     = 1'b1;
    bus.wr_addr    = 12'h100;
    bus.wr_data    = 16'h1234;
    repeat (4) @(negedge clk_72m);
    bus.char_valid = 1'b0;
    bus.wr_req     = 1'b0;
    drain("arb_drain");
    check("arb_cursor", {cursor_row, cursor_col}, {5'd0, 5'd6});

    // Out-of-range direct write: ack without strobe.
    exp_q.push_back('{ce: 1'b0, ack: 1'b1, addr: 12'd0, data: 16'd0});
    bus.wr_req  = 1'b1;
    bus.wr_addr = 12'd750;
    bus.wr_data = 16'hBEEF;
    @(negedge clk_72m);
    bus.wr_req  = 1'b0;
    drain("oor_drain");

    // Unused control byte, CR, then BS at column 0: no writes.
    send_char(8'h01);
    check("ctl_cursor", {cursor_row, cursor_col}, {5'd0, 5'd6});
    send_char(8'h0D);
    send_char(8'h08);
    drain("bs_col0_drain");
    check("bs_col0_cursor", {cursor_row, cursor_col}, {5'd0, 5'd0});
    send_print(8'h42, 0, 0);
    drain("b_drain");

    // Form feed, then reset 100 cycles into the clear.
    push_clear(0, 750);
    send_char(8'h0C);
    check("ff_busy", busy, 1);
    repeat (100) @(negedge clk_72m);
    #3 reset = 1'b0;
    #1;
    check("async_rst_outputs", {vram_ce, bus.wr_ack, vram_addr, vram_data}, 32'h0);
    check("async_rst_cursor", {cursor_row, cursor_col}, 32'h0);
    exp_q.delete();
    @(negedge clk_72m);
    push_clear(0, 750);
    reset = 1'b1;
    count_busy("restart_busy_cycles");
    drain("restart_drain");
    check("restart_cursor", {cursor_row, cursor_col}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
